// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcode/funct constants, ALU codes, mux encodings and FSM states
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_SEXT = 2'b10;
  localparam logic [1:0] SRC_B_ZEXT = 2'b11;

  localparam logic [1:0] PC_SRC_ALU  = 2'b00;
  localparam logic [1:0] PC_SRC_OUT  = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_WB_R     = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_WB_I     = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WB   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_FAULT    = 4'd12
  } state_t;

endpackage

// File: rtl/multicycle_control_unit_alu_op_decode.sv
// rtl/multicycle_control_unit_alu_op_decode.sv - op/funct to ALU op, immediate-extend kind and legality
module alu_op_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       imm_zext,
  output logic       legal
);

  always_comb begin
    alu_op   = ALU_ADD;
    imm_zext = 1'b0;
    legal    = 1'b1;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_SLT:  alu_op = ALU_SLT;
          default: legal  = 1'b0;
        endcase
      end
      OP_ADDI: alu_op = ALU_ADD;
      OP_SLTI: alu_op = ALU_SLT;
      OP_ANDI: begin alu_op = ALU_AND; imm_zext = 1'b1; end
      OP_ORI:  begin alu_op = ALU_OR;  imm_zext = 1'b1; end
      OP_XORI: begin alu_op = ALU_XOR; imm_zext = 1'b1; end
      OP_LW, OP_SW: alu_op = ALU_ADD;
      OP_BEQ, OP_BNE: alu_op = ALU_SUB;
      OP_J: alu_op = ALU_ADD;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle MIPS-subset control FSM; PERF_CNT_EN adds instret counter
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int STATE_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_we,
  output logic                ir_we,
  output logic                reg_we,
  output logic                rdts,
  output logic                mem_to_reg,
  output logic                iord,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          pc_src,
  output logic                mem_re,
  output logic                mem_we,
  output logic                fault,
  output logic [STATE_W-1:0]  state
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]         instret
`endif
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t           st, nxt;
  logic [CNT_W-1:0] tcnt;
  logic [2:0]       dec_alu_op, aop;
  logic             imm_zext, legal, is_wait, timeout;

  alu_op_decode u_dec (
    .op       (op),
    .funct    (funct),
    .alu_op   (dec_alu_op),
    .imm_zext (imm_zext),
    .legal    (legal)
  );

  assign is_wait = (st == ST_FETCH) || (st == ST_MEM_RD) || (st == ST_MEM_WR);
  // A ready arriving on the limit cycle still completes the access.
  assign timeout = (MEM_TIMEOUT > 0) && is_wait && !mem_ready && (tcnt == CNT_W'(MEM_TIMEOUT));

  always_comb begin
    nxt = st;
    case (st)
      ST_FETCH:    if (mem_ready) nxt = ST_DECODE; else if (timeout) nxt = ST_FAULT;
      ST_DECODE: begin
        if (!legal) nxt = ST_FAULT;
        else begin
          case (op)
            OP_RTYPE:       nxt = ST_EXEC_R;
            OP_LW, OP_SW:   nxt = ST_MEM_ADDR;
            OP_BEQ, OP_BNE: nxt = ST_BRANCH;
            OP_J:           nxt = ST_JUMP;
            default:        nxt = ST_EXEC_I;
          endcase
        end
      end
      ST_EXEC_R:   nxt = ST_WB_R;
      ST_EXEC_I:   nxt = ST_WB_I;
      ST_MEM_ADDR: nxt = (op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (mem_ready) nxt = ST_MEM_WB; else if (timeout) nxt = ST_FAULT;
      ST_MEM_WR:   if (mem_ready) nxt = ST_FETCH; else if (timeout) nxt = ST_FAULT;
      ST_WB_R, ST_WB_I, ST_MEM_WB, ST_BRANCH, ST_JUMP: nxt = ST_FETCH;
      ST_FAULT:    nxt = ST_FAULT;
      default:     nxt = ST_FAULT;
    endcase
  end

  // Counter restarts on every state change so each wait state gets a fresh budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= ST_FETCH;
      tcnt <= '0;
    end else begin
      st <= nxt;
      if (nxt != st) tcnt <= '0;
      else if (is_wait && !mem_ready) tcnt <= tcnt + CNT_W'(1);
    end
  end

  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    rdts       = 1'b0;
    mem_to_reg = 1'b0;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    aop        = ALU_ADD;
    pc_src     = PC_SRC_ALU;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    fault      = 1'b0;
    case (st)
      ST_FETCH: begin
        mem_re    = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
      end
      ST_DECODE:   alu_src_b = SRC_B_SEXT;
      ST_EXEC_R:   begin alu_src_a = 1'b1; aop = dec_alu_op; end
      ST_WB_R:     begin reg_we = 1'b1; rdts = 1'b1; end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = imm_zext ? SRC_B_ZEXT : SRC_B_SEXT;
        aop       = dec_alu_op;
      end
      ST_WB_I:     reg_we = 1'b1;
      ST_MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = SRC_B_SEXT; end
      ST_MEM_RD:   begin mem_re = 1'b1; iord = 1'b1; end
      ST_MEM_WB:   begin reg_we = 1'b1; mem_to_reg = 1'b1; end
      ST_MEM_WR:   begin mem_we = 1'b1; iord = 1'b1; end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        aop       = ALU_SUB;
        pc_src    = PC_SRC_OUT;
        pc_we     = (op == OP_BNE) ? ~zero : zero;
      end
      ST_JUMP:     begin pc_src = PC_SRC_JUMP; pc_we = 1'b1; end
      ST_FAULT:    fault = 1'b1;
      default:     ;
    endcase
  end

  assign alu_op = ALU_OP_W'(aop);
  assign state  = STATE_W'(st);

`ifdef PERF_CNT_EN
  logic retire;
  assign retire = (nxt == ST_FETCH) &&
                  (st inside {ST_WB_R, ST_WB_I, ST_MEM_WB, ST_MEM_WR, ST_BRANCH, ST_JUMP});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) instret <= '0;
    else if (retire) instret <= instret + 32'd1;
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit
module tb_multicycle_control_unit;
  import cpu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst, zero, mem_ready;
  logic [5:0] op, funct;
  logic       pc_we, ir_we, reg_we, rdts, mem_to_reg, iord, alu_src_a, mem_re, mem_we, fault;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic [3:0] state;
`ifdef PERF_CNT_EN
  logic [31:0] instret;
`endif

  int errors = 0;
  int checks = 0;
  int n_ret  = 0;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] w;
    logic [16:0] m;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [16:0] M_EN   = 17'h1C007;
  localparam logic [16:0] M_RD   = 17'h02000;
  localparam logic [16:0] M_M2R  = 17'h01000;
  localparam logic [16:0] M_IORD = 17'h00800;
  localparam logic [16:0] M_A    = 17'h00400;
  localparam logic [16:0] M_B    = 17'h00300;
  localparam logic [16:0] M_AOP  = 17'h000E0;
  localparam logic [16:0] M_PS   = 17'h00018;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .rdts(rdts), .mem_to_reg(mem_to_reg),
    .iord(iord), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .mem_re(mem_re), .mem_we(mem_we), .fault(fault), .state(state)
`ifdef PERF_CNT_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  wire [16:0] obs = {pc_we, ir_we, reg_we, rdts, mem_to_reg, iord, alu_src_a,
                     alu_src_b, alu_op, pc_src, mem_re, mem_we, fault};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [16:0] mk(input logic pcw, irw, rw, rd, m2r, io, a,
                                     input logic [1:0] b, input logic [2:0] aop,
                                     input logic [1:0] ps, input logic re, we, f);
    return {pcw, irw, rw, rd, m2r, io, a, b, aop, ps, re, we, f};
  endfunction

  // One cycle: drive mem_ready, queue the expectation, compare once outputs settle.
  task automatic cyc(input logic mr, input state_t st, input logic [16:0] w,
                     input logic [16:0] m, input string tag);
    exp_t e;
    mem_ready = mr;
    e.st = st; e.w = w; e.m = m;
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    check($sformatf("%s/state", tag), 32'(state), 32'(e.st));
    check($sformatf("%s/ctrl", tag), 32'(obs & e.m), 32'(e.w & e.m));
    @(posedge clk); #1;
  endtask

  task automatic c_fetch(input logic mr, input string tag);
    cyc(mr, ST_FETCH, mk(mr, mr, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 1, 0, 0),
        M_EN | M_IORD | M_A | M_B | M_AOP | M_PS, tag);
  endtask
  task automatic c_decode(input string tag);
    cyc(1'b1, ST_DECODE, mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 3'b010, 2'b00, 0, 0, 0),
        M_EN | M_A | M_B | M_AOP, tag);
  endtask
  task automatic c_exec(input state_t st, input logic [1:0] b, input logic [2:0] aop, input string tag);
    cyc(1'b1, st, mk(0, 0, 0, 0, 0, 0, 1, b, aop, 2'b00, 0, 0, 0), M_EN | M_A | M_B | M_AOP, tag);
  endtask
  task automatic c_wb(input state_t st, input logic rd, input logic m2r, input string tag);
    cyc(1'b1, st, mk(0, 0, 1, rd, m2r, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0), M_EN | M_RD | M_M2R, tag);
  endtask
  task automatic c_mem(input logic mr, input state_t st, input logic re, input logic we, input string tag);
    cyc(mr, st, mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, re, we, 0), M_EN | M_IORD, tag);
  endtask
  task automatic c_fault(input logic mr, input string tag);
    cyc(mr, ST_FAULT, 17'h00001, M_EN, tag);
  endtask

  task automatic set_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
    op = o; funct = f; zero = z;
  endtask

  task automatic run_r(input logic [5:0] f, input logic [2:0] aop, input string tag);
    set_instr(OP_RTYPE, f, 1'b0);
    c_fetch(1'b1, tag); c_decode(tag);
    c_exec(ST_EXEC_R, 2'b00, aop, tag);
    c_wb(ST_WB_R, 1'b1, 1'b0, tag);
    n_ret++;
  endtask

  task automatic run_i(input logic [5:0] o, input logic [1:0] b, input logic [2:0] aop, input string tag);
    set_instr(o, 6'h15, 1'b0);
    c_fetch(1'b1, tag); c_decode(tag);
    c_exec(ST_EXEC_I, b, aop, tag);
    c_wb(ST_WB_I, 1'b0, 1'b0, tag);
    n_ret++;
  endtask

  task automatic run_mem(input logic is_lw, input int waits, input string tag);
    set_instr(is_lw ? OP_LW : OP_SW, 6'h00, 1'b0);
    c_fetch(1'b1, tag); c_decode(tag);
    cyc(1'b1, ST_MEM_ADDR, mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0, 0),
        M_EN | M_A | M_B | M_AOP, tag);
    for (int i = 0; i < waits; i++)
      c_mem(1'b0, is_lw ? ST_MEM_RD : ST_MEM_WR, is_lw, !is_lw, tag);
    c_mem(1'b1, is_lw ? ST_MEM_RD : ST_MEM_WR, is_lw, !is_lw, tag);
    if (is_lw) c_wb(ST_MEM_WB, 1'b0, 1'b1, tag);
    n_ret++;
  endtask

  task automatic run_br(input logic [5:0] o, input logic z, input logic pcw, input string tag);
    set_instr(o, 6'h00, z);
    c_fetch(1'b1, tag); c_decode(tag);
    cyc(1'b1, ST_BRANCH, mk(pcw, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0, 0, 0),
        M_EN | M_A | M_B | M_AOP | M_PS, tag);
    n_ret++;
  endtask

  task automatic run_j(input string tag);
    set_instr(OP_J, 6'h00, 1'b0);
    c_fetch(1'b1, tag); c_decode(tag);
    cyc(1'b1, ST_JUMP, mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 0, 0, 0), M_EN | M_PS, tag);
    n_ret++;
  endtask

  task automatic chk_ret(input string tag);
`ifdef PERF_CNT_EN
    check(tag, instret, 32'(n_ret));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; mem_ready = 1'b0;
    exp_q.delete();
    n_ret = 0;
    #1;
    check($sformatf("%s/state", tag), 32'(state), 32'(ST_FETCH));
    check($sformatf("%s/ctrl", tag), 32'(obs & (M_EN | M_IORD | M_A | M_B | M_AOP | M_PS)),
          32'(mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 1, 0, 0)));
    chk_ret($sformatf("%s/instret", tag));
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; zero = 1'b0; mem_ready = 1'b0; op = 6'h00; funct = 6'h00;
    @(posedge clk); #1;
    do_reset("reset");

    run_r(FN_ADD, 3'b010, "r_add");
    run_r(FN_SUB, 3'b110, "r_sub");
    run_r(FN_SLT, 3'b111, "r_slt");
    run_i(OP_XORI, 2'b11, 3'b011, "xori");
    run_i(OP_ADDI, 2'b10, 3'b010, "addi");
    chk_ret("instret5");
    run_i(OP_ANDI, 2'b11, 3'b000, "andi");
    run_i(OP_SLTI, 2'b10, 3'b111, "slti");
    run_mem(1'b1, 3, "lw_wait");
    run_mem(1'b0, 2, "sw_wait");
    run_mem(1'b1, 0, "lw_fast");
    run_br(OP_BEQ, 1'b1, 1'b1, "beq_taken");
    run_br(OP_BEQ, 1'b0, 1'b0, "beq_not");
    run_br(OP_BNE, 1'b0, 1'b1, "bne_taken");
    run_br(OP_BNE, 1'b1, 1'b0, "bne_not");
    run_j("jump");
    chk_ret("instret_all");

    // Ready arriving on the limit cycle still completes the fetch.
    do_reset("reset_to1");
    set_instr(OP_ADDI, 6'h00, 1'b0);
    for (int i = 0; i < 15; i++) c_fetch(1'b0, "to_wait");
    c_fetch(1'b1, "to_limit_ready");
    c_decode("to_limit_ready");
    c_exec(ST_EXEC_I, 2'b10, 3'b010, "to_limit_ready");
    c_wb(ST_WB_I, 1'b0, 1'b0, "to_limit_ready");
    n_ret++;
    for (int i = 0; i < 16; i++) c_fetch(1'b0, "to_expire");
    c_fault(1'b1, "to_fault");
    c_fault(1'b0, "to_fault");
    c_fault(1'b1, "to_fault_sticky");
    chk_ret("instret_frozen");

    do_reset("reset_ill");
    run_r(FN_ADD, 3'b010, "post_fault_r");
    set_instr(6'b111111, 6'h00, 1'b0);
    c_fetch(1'b1, "ill_op"); c_decode("ill_op");
    c_fault(1'b1, "ill_op"); c_fault(1'b1, "ill_op"); c_fault(1'b0, "ill_op_sticky");

    do_reset("reset_fn");
    set_instr(OP_RTYPE, 6'b000000, 1'b0);
    c_fetch(1'b1, "ill_funct"); c_decode("ill_funct");
    c_fault(1'b1, "ill_funct");

    // Reset mid-MEM_RD must drop the data-read request without waiting for a clock.
    do_reset("reset_mid");
    run_r(FN_OR, 3'b001, "pre_mid");
    set_instr(OP_LW, 6'h00, 1'b0);
    c_fetch(1'b1, "mid"); c_decode("mid");
    cyc(1'b1, ST_MEM_ADDR, mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0, 0),
        M_EN | M_A | M_B | M_AOP, "mid");
    c_mem(1'b0, ST_MEM_RD, 1'b1, 1'b0, "mid");
    mem_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid/state", 32'(state), 32'(ST_FETCH));
    check("rst_mid/iord", 32'(iord), 32'd0);
    check("rst_mid/reg_we", 32'(reg_we), 32'd0);
    n_ret = 0;
    chk_ret("rst_mid/instret");
    @(posedge clk); #1;
    rst = 1'b0;
    run_j("post_mid_j");
    chk_ret("instret_post_mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
